// File: rtl/iir_pkg.sv
// Shared definitions for the order-N direct-form-I IIR filter:
// signed saturation helper, accumulator width and default N=1 coefficients.
package iir_pkg;

    // Working width for saturation and output-gain arithmetic. It must exceed
    // both the accumulator width and BITWIDTH+GAINL.
    localparam int SAT_W = 256;

    // Accumulator width: full products plus growth for 2N+1 terms.
    function automatic int acc_w(input int n, input int bw);
        return 2 * bw + $clog2(2 * n + 1);
    endfunction

    // Clamp a wide signed value to the signed range of 'width' bits.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                    input int                      width);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (256'sd1 <<< (width - 1)) - 256'sd1;
        min_v = -max_v - 256'sd1;
        if (v > max_v) begin
            return max_v;
        end else if (v < min_v) begin
            return min_v;
        end else begin
            return v;
        end
    endfunction

    // Default unity-DC-gain low-pass for N=1, BITWIDTH=32, FAC=20:
    // b0 = b1 = 0.125, a1 = -0.75.
    localparam logic [63:0] DEF_B_COEF = {32'sd131072, 32'sd131072};
    localparam logic [31:0] DEF_A_COEF = 32'hFFF4_0000;

endpackage

// File: rtl/iir_mac.sv
// Combinational signed multiply-accumulate over the x and y history vectors.
// x_vec_i[k] is x[n-k] (k = 0..N), y_vec_i[k-1] is y[n-k] (k = 1..N).
module iir_mac
    import iir_pkg::*;
#(
    parameter int                      N        = 1,
    parameter int                      BITWIDTH = 32,
    parameter int                      ACC_W    = acc_w(1, 32),
    parameter logic [(N+1)*BITWIDTH-1:0] B_COEF = DEF_B_COEF,
    parameter logic [N*BITWIDTH-1:0]     A_COEF = DEF_A_COEF
) (
    input  logic [(N+1)*BITWIDTH-1:0] x_vec_i,
    input  logic [N*BITWIDTH-1:0]     y_vec_i,
    output logic signed [ACC_W-1:0]   acc_o
);

    logic signed [2*BITWIDTH-1:0] prod_s;

    // Sum feed-forward products and subtract feedback products at full precision.
    always_comb begin
        acc_o  = {ACC_W{1'b0}};
        prod_s = {(2*BITWIDTH){1'b0}};
        for (int k = 0; k <= N; k++) begin
            prod_s = $signed(x_vec_i[k*BITWIDTH +: BITWIDTH]) *
                     $signed(B_COEF[k*BITWIDTH +: BITWIDTH]);
            acc_o  = acc_o + ACC_W'(prod_s);
        end
        for (int k = 1; k <= N; k++) begin
            prod_s = $signed(y_vec_i[(k-1)*BITWIDTH +: BITWIDTH]) *
                     $signed(A_COEF[(k-1)*BITWIDTH +: BITWIDTH]);
            acc_o  = acc_o - ACC_W'(prod_s);
        end
    end

endmodule

// File: rtl/iir_n.sv
// Order-N direct-form-I IIR filter, one sample per clock, latency 1.
// Keeps the x/y history registers, quantises and saturates the accumulator,
// and applies a power-of-two output gain that stays outside the feedback loop.
module iir_n
    import iir_pkg::*;
#(
    parameter int                        N        = 1,
    parameter int                        BITWIDTH = 32,
    parameter int                        FAC      = 20,
    parameter int                        GAINL    = 0,
    parameter int                        GAINM    = 0,
    parameter logic [(N+1)*BITWIDTH-1:0] B_COEF   = DEF_B_COEF,
    parameter logic [N*BITWIDTH-1:0]     A_COEF   = DEF_A_COEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [BITWIDTH-1:0] x,
    output logic signed [BITWIDTH-1:0] y
);

    localparam int ACC_W = acc_w(N, BITWIDTH);

    logic signed [BITWIDTH-1:0] x_hist_q [N];
    logic signed [BITWIDTH-1:0] y_hist_q [N];
    logic [(N+1)*BITWIDTH-1:0]  x_vec_s;
    logic [N*BITWIDTH-1:0]      y_vec_s;
    logic signed [ACC_W-1:0]    acc_s;
    logic signed [SAT_W-1:0]    acc_ext_s;
    logic signed [SAT_W-1:0]    q_wide_s;
    logic signed [SAT_W-1:0]    q_ext_s;
    logic signed [SAT_W-1:0]    gain_s;
    logic signed [SAT_W-1:0]    o_wide_s;
    logic signed [BITWIDTH-1:0] q_s;
    logic signed [BITWIDTH-1:0] y_d;
    logic signed [BITWIDTH-1:0] y_q;
    logic                       unused_s;

    assign x_vec_s[0 +: BITWIDTH] = x;

    generate
        for (genvar k = 0; k < N; k++) begin : g_hist
            assign x_vec_s[(k+1)*BITWIDTH +: BITWIDTH] = x_hist_q[k];
            assign y_vec_s[k*BITWIDTH +: BITWIDTH]     = y_hist_q[k];
            if (k == 0) begin : g_head
                // Newest history slot: take the current input and quantised output.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        x_hist_q[k] <= {BITWIDTH{1'b0}};
                        y_hist_q[k] <= {BITWIDTH{1'b0}};
                    end else begin
                        x_hist_q[k] <= x;
                        y_hist_q[k] <= q_s;
                    end
                end
            end else begin : g_tail
                // Older history slots shift down one position each sample.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        x_hist_q[k] <= {BITWIDTH{1'b0}};
                        y_hist_q[k] <= {BITWIDTH{1'b0}};
                    end else begin
                        x_hist_q[k] <= x_hist_q[k-1];
                        y_hist_q[k] <= y_hist_q[k-1];
                    end
                end
            end
        end
    endgenerate

    iir_mac #(
        .N        (N),
        .BITWIDTH (BITWIDTH),
        .ACC_W    (ACC_W),
        .B_COEF   (B_COEF),
        .A_COEF   (A_COEF)
    ) u_mac (
        .x_vec_i (x_vec_s),
        .y_vec_i (y_vec_s),
        .acc_o   (acc_s)
    );

    // Quantise with floor (arithmetic shift), saturate, then apply output gain.
    always_comb begin
        acc_ext_s = {{(SAT_W-ACC_W){acc_s[ACC_W-1]}}, acc_s};
        q_wide_s  = sat(acc_ext_s >>> FAC, BITWIDTH);
        q_s       = q_wide_s[BITWIDTH-1:0];
        q_ext_s   = {{(SAT_W-BITWIDTH){q_s[BITWIDTH-1]}}, q_s};
        gain_s    = (q_ext_s <<< GAINL) >>> GAINM;
        o_wide_s  = sat(gain_s, BITWIDTH);
        y_d       = o_wide_s[BITWIDTH-1:0];
    end

    // Registered filter output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_q <= {BITWIDTH{1'b0}};
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

    // Upper bits of the saturated values are identical to the sign bit by construction.
    assign unused_s = ^{q_wide_s[SAT_W-1:BITWIDTH], o_wide_s[SAT_W-1:BITWIDTH]};

endmodule

// File: tb/tb_iir_n.sv
// Self-checking bench for iir_n: directed impulse/step/reset/gain scenarios and
// a random + sine stream against a behavioural reference model.
module tb_iir_n;

    localparam int  N      = 1;
    localparam int  FAC    = 20;
    localparam longint B0  = 131072;
    localparam longint B1  = 131072;
    localparam longint A1  = -786432;
    localparam longint YMAX = 64'sd2147483647;
    localparam longint YMIN = -64'sd2147483648;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [31:0] x   = 32'sd0;
    logic signed [31:0] xg  = 32'sd0;
    logic signed [31:0] y;
    logic signed [31:0] yg;

    int checks   = 0;
    int failures = 0;

    // reference model state: previous input and previous quantised output
    longint mx_prev;
    longint my_prev;

    always #5 clk = ~clk;

    iir_n u_dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y)
    );

    iir_n #(.GAINL(28)) u_gain (
        .clk (clk),
        .rst (rst),
        .x   (xg),
        .y   (yg)
    );

    task automatic model_reset();
        mx_prev = 0;
        my_prev = 0;
    endtask

    // y[n] = floor((b0*x[n] + b1*x[n-1] - a1*y[n-1]) / 2^FAC), clamped to 32 bits
    task automatic model_step(input longint xin, output longint ye);
        logic signed [127:0] acc;
        longint q;
        acc = 128'(B0 * xin) + 128'(B1 * mx_prev) - 128'(A1 * my_prev);
        acc = acc >>> FAC;
        if (acc > 128'(YMAX))      q = YMAX;
        else if (acc < 128'(YMIN)) q = YMIN;
        else                       q = longint'(acc);
        mx_prev = xin;
        my_prev = q;
        ye = q;
    endtask

    // one sample: drive at negedge, check 1 time unit after the rising edge
    task automatic step(input int xin);
        @(negedge clk);
        x = xin;
        @(posedge clk);
        #1;
    endtask

    // short reset pulse between edges; one zero sample follows
    task automatic do_reset();
        @(negedge clk);
        x   = 32'sd0;
        xg  = 32'sd0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (y !== 32'sd0) begin
            failures++;
            $display("FAIL reset_y got=%0d want=0", y);
        end
        checks++;
        if (yg !== 32'sd0) begin
            failures++;
            $display("FAIL reset_yg got=%0d want=0", yg);
        end
    endtask

    task automatic check_impulse(input string tag);
        int imp [6] = '{128, 224, 168, 126, 94, 70};
        longint ye;
        for (int i = 0; i < 6; i++) begin
            step(i == 0 ? 1024 : 0);
            model_step(i == 0 ? 1024 : 0, ye);
            checks++;
            if (y !== imp[i] || ye != longint'(imp[i])) begin
                failures++;
                $display("FAIL %s[%0d] got=%0d model=%0d want=%0d", tag, i, y, ye, imp[i]);
            end
        end
    endtask

    task automatic test_impulse();
        int prev;
        do_reset();
        check_impulse("impulse");
        prev = 70;
        for (int i = 0; i < 60; i++) begin
            step(0);
            checks++;
            if (y > prev || y < 0) begin
                failures++;
                $display("FAIL impulse_decay[%0d] got=%0d prev=%0d", i, y, prev);
            end
            prev = int'(y);
        end
        for (int i = 0; i < 20; i++) begin
            step(0);
            checks++;
            if (y !== 32'sd0) begin
                failures++;
                $display("FAIL zero_hold[%0d] got=%0d want=0", i, y);
            end
        end
    endtask

    task automatic test_step();
        int tab [3] = '{125, 343, 507};
        int prev;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1000);
            checks++;
            if (y !== tab[i]) begin
                failures++;
                $display("FAIL step[%0d] got=%0d want=%0d", i, y, tab[i]);
            end
        end
        prev = 507;
        for (int i = 0; i < 97; i++) begin
            step(1000);
            checks++;
            if (y < prev || y > 1000) begin
                failures++;
                $display("FAIL step_mono[%0d] got=%0d prev=%0d max=1000", i, y, prev);
            end
            prev = int'(y);
        end
        checks++;
        if (y < 996 || y > 1000) begin
            failures++;
            $display("FAIL step_final got=%0d want=996..1000", y);
        end
    endtask

    task automatic test_neg_step();
        int tab [2] = '{-125, -344};
        int prev;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(-1000);
            checks++;
            if (y !== tab[i]) begin
                failures++;
                $display("FAIL negstep[%0d] got=%0d want=%0d", i, y, tab[i]);
            end
        end
        prev = -344;
        for (int i = 0; i < 98; i++) begin
            step(-1000);
            checks++;
            if (y > prev) begin
                failures++;
                $display("FAIL negstep_mono[%0d] got=%0d prev=%0d", i, y, prev);
            end
            prev = int'(y);
        end
        checks++;
        if (y < -1004 || y > -996) begin
            failures++;
            $display("FAIL negstep_final got=%0d want=-1004..-996", y);
        end
    endtask

    task automatic test_reset_midstream();
        longint ye;
        int     xin;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            xin = int'($urandom_range(1400, 0)) - 700;
            step(xin);
            model_step(xin, ye);
            checks++;
            if (y !== ye) begin
                failures++;
                $display("FAIL mid_stream[%0d] got=%0d want=%0d", i, y, ye);
            end
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (y !== 32'sd0) begin
            failures++;
            $display("FAIL async_reset got=%0d want=0", y);
        end
        @(posedge clk);
        #1;
        checks++;
        if (y !== 32'sd0) begin
            failures++;
            $display("FAIL reset_held got=%0d want=0", y);
        end
        @(negedge clk);
        x   = 32'sd0;
        rst = 1'b1;
        model_reset();
        check_impulse("impulse_after_reset");
    endtask

    task automatic test_gain();
        do_reset();
        xg = 32'sd1073741824;
        for (int i = 0; i < 10; i++) begin
            step(0);
            checks++;
            if (yg !== 32'sh7FFF_FFFF) begin
                failures++;
                $display("FAIL gain_pos[%0d] got=%0d want=2147483647", i, yg);
            end
        end
        do_reset();
        xg = -32'sd1073741824;
        for (int i = 0; i < 10; i++) begin
            step(0);
            checks++;
            if (yg !== 32'sh8000_0000) begin
                failures++;
                $display("FAIL gain_neg[%0d] got=%0d want=-2147483648", i, yg);
            end
        end
    endtask

    task automatic test_random();
        longint ye;
        int     xin;
        do_reset();
        for (int i = 0; i < 700; i++) begin
            if (i < 600) begin
                xin = int'($urandom_range(1400, 0)) - 700;
            end else begin
                xin = $rtoi(300.0 * $sin(2.0 * 3.14159265358979 * real'(i - 600) / 20.0));
            end
            step(xin);
            model_step(xin, ye);
            checks++;
            if (y !== ye) begin
                failures++;
                $display("FAIL random[%0d] x=%0d got=%0d want=%0d", i, xin, y, ye);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_impulse();
        test_step();
        test_neg_step();
        test_reset_midstream();
        test_gain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
